// File: rtl/rs_entry_scheduler.sv
// rs_entry_scheduler: allocates, issues and releases reservation-station entries (IDs are 1-based, 0 = none).
// Optional build macro RS_RR_ISSUE_EN: defined = round-robin issue selection, undefined = fixed lowest-index priority.
module rs_entry_scheduler #(
    parameter int NUM_RS = 8,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [ID_W-1:0]   alloc_id,
    input  logic [NUM_RS-1:0] rdy_vec,
    output logic              issue_valid,
    output logic [ID_W-1:0]   issue_id,
    input  logic              issue_ack,
    input  logic              done_valid,
    input  logic [ID_W-1:0]   done_id,
    output logic [NUM_RS-1:0] busy_vec,
    output logic              full,
    output logic              empty,
    output logic              err
);
    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ISSUED = 2'd2;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_RS);

    logic [NUM_RS-1:0][1:0] st_q, st_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [ID_W-1:0]        issue_id_q, issue_id_d, sel_id;
    logic                   err_q, err_d;
    logic [NUM_RS-1:0]      free_vec, wait_vec, acked_vec, done_hit, cand_vec;
    logic                   fire, load;

    assign busy_vec    = ~free_vec;
    assign full        = ~|free_vec;
    assign empty       = &free_vec;
    assign alloc_gnt   = alloc_req & ~full;
    assign fire        = issue_valid_q & issue_ack;
    assign load        = ~issue_valid_q | issue_ack;
    assign issue_valid = issue_valid_q;
    assign issue_id    = issue_id_q;
    assign err         = err_q;

    // Decode entry states and pick the lowest-index free entry for allocation
    always_comb begin
        free_vec = '0;
        wait_vec = '0;
        alloc_id = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            free_vec[i] = st_q[i] == ST_FREE;
            wait_vec[i] = st_q[i] == ST_WAIT;
            if (st_q[i] == ST_FREE) alloc_id = ID_W'(i + 1);
        end
    end

    // Ack/done matching; the entry acked this cycle is not a candidate for the next offer
    always_comb begin
        acked_vec = '0;
        done_hit  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            acked_vec[i] = fire && issue_id_q == ID_W'(i + 1);
            done_hit[i]  = done_valid && done_id == ID_W'(i + 1) && st_q[i] == ST_ISSUED;
        end
        cand_vec = wait_vec & rdy_vec & ~acked_vec;
    end

`ifdef RS_RR_ISSUE_EN
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [NUM_RS-1:0] rot;

    // Round-robin: start just after the entry acked now, otherwise after the last acked entry
    always_comb begin
        rr_d   = fire ? (issue_id_q == LAST_ID ? '0 : issue_id_q) : rr_q;
        rot    = NUM_RS'({cand_vec, cand_vec} >> rr_d);
        sel_id = '0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            if (rot[k]) sel_id = ID_W'((int'(rr_d) + k >= NUM_RS) ? int'(rr_d) + k - NUM_RS + 1 : int'(rr_d) + k + 1);
        end
    end

    // Round-robin pointer (0-based index where the next search begins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`else
    // Fixed priority: lowest-index candidate wins
    always_comb begin
        sel_id = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (cand_vec[i]) sel_id = ID_W'(i + 1);
        end
    end
`endif

    // Entry transitions, issue-slot reload/hold and sticky error
    always_comb begin
        st_d = st_q;
        for (int i = 0; i < NUM_RS; i++) begin
            if (alloc_gnt && alloc_id == ID_W'(i + 1)) st_d[i] = ST_WAIT;
            if (acked_vec[i]) st_d[i] = ST_ISSUED;
            if (done_hit[i]) st_d[i] = ST_FREE;
        end
        issue_valid_d = load ? |cand_vec : issue_valid_q;
        issue_id_d    = load ? sel_id : issue_id_q;
        err_d         = err_q | (done_valid & ~|done_hit) | (issue_ack & ~issue_valid_q);
    end

    // State registers with asynchronous reset that discards every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= '0;
            issue_valid_q <= 1'b0;
            issue_id_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            st_q          <= st_d;
            issue_valid_q <= issue_valid_d;
            issue_id_q    <= issue_id_d;
            err_q         <= err_d;
        end
    end
endmodule

// File: tb/tb_rs_entry_scheduler.sv
// tb_rs_entry_scheduler: directed self-checking bench for rs_entry_scheduler (default fixed-priority build)
module tb_rs_entry_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [3:0] alloc_id;
    logic [7:0] rdy_vec = 8'h00;
    logic       issue_valid;
    logic [3:0] issue_id;
    logic       issue_ack = 1'b0;
    logic       done_valid = 1'b0;
    logic [3:0] done_id = 4'd0;
    logic [7:0] busy_vec;
    logic       full;
    logic       empty;
    logic       err;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    rs_entry_scheduler #(.NUM_RS(8), .ID_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .rdy_vec(rdy_vec), .issue_valid(issue_valid), .issue_id(issue_id), .issue_ack(issue_ack),
        .done_valid(done_valid), .done_id(done_id), .busy_vec(busy_vec), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_expect(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed issue_id %0h with no expected entry queued", tag, issue_id);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " valid"}, issue_valid, 1);
            chk({tag, " id"}, issue_id, e);
        end
        issue_ack = 1'b1;
        cyc();
    endtask

    initial begin
        #12;
        chk("rst busy", busy_vec, 8'h00);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst ivalid", issue_valid, 0);
        chk("rst iid", issue_id, 0);
        chk("rst err", err, 0);
        chk("rst alloc_id", alloc_id, 1);
        cyc();
        rst_n = 1'b1;
        // fill all entries
        for (int i = 1; i <= 8; i++) begin
            alloc_req = 1'b1;
            #1;
            chk("fill gnt", alloc_gnt, 1);
            chk("fill id", alloc_id, i);
            cyc();
        end
        #1;
        chk("fill full", full, 1);
        chk("fill busy", busy_vec, 8'hff);
        chk("fill9 gnt", alloc_gnt, 0);
        chk("fill9 id", alloc_id, 0);
        alloc_req = 1'b0;
        chk("fill no issue", issue_valid, 0);
        // fixed priority issue with preemption by re-allocated entry 1
        rdy_vec = 8'hff;
        exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        cyc();
        ack_expect("fp");
        ack_expect("fp");
        ack_expect("fp");
        issue_ack = 1'b0;
        rdy_vec = 8'hf7;
        done_valid = 1'b1; done_id = 4'd1;
        cyc();
        done_valid = 1'b0;
        #1;
        chk("hold id", issue_id, 4);
        chk("refree id", alloc_id, 1);
        alloc_req = 1'b1;
        cyc();
        alloc_req = 1'b0;
        chk("hold id2", issue_id, 4);
        chk("realloc full", full, 1);
        rdy_vec = 8'hff;
        exp_q.push_back(4'd4); exp_q.push_back(4'd1);
        for (int i = 5; i <= 8; i++) exp_q.push_back(4'(i));
        for (int i = 0; i < 6; i++) ack_expect("pre");
        issue_ack = 1'b0;
        chk("drain valid", issue_valid, 0);
        chk("drain id", issue_id, 0);
        chk("drain err", err, 0);
        // done and alloc in the same cycle while full
        done_valid = 1'b1; done_id = 4'd3; alloc_req = 1'b1;
        #1;
        chk("samecyc gnt", alloc_gnt, 0);
        chk("samecyc id", alloc_id, 0);
        cyc();
        done_valid = 1'b0;
        #1;
        chk("next gnt", alloc_gnt, 1);
        chk("next id", alloc_id, 3);
        cyc();
        alloc_req = 1'b0;
        chk("alloc no issue yet", issue_valid, 0);
        exp_q.push_back(4'd3);
        cyc();
        ack_expect("reissue");
        issue_ack = 1'b0;
        chk("reissue drain", issue_valid, 0);
        // illegal completions
        done_valid = 1'b1; done_id = 4'd5;
        cyc();
        done_valid = 1'b0;
        rdy_vec = 8'h00;
        alloc_req = 1'b1;
        #1;
        chk("e alloc id", alloc_id, 5);
        chk("e err clean", err, 0);
        cyc();
        alloc_req = 1'b0;
        done_valid = 1'b1; done_id = 4'd5;
        cyc();
        chk("done wait err", err, 1);
        chk("done wait busy", busy_vec, 8'hff);
        done_id = 4'd0;
        cyc();
        chk("done0 err", err, 1);
        chk("done0 busy", busy_vec, 8'hff);
        done_id = 4'd9;
        cyc();
        done_valid = 1'b0;
        chk("done9 err", err, 1);
        chk("done9 busy", busy_vec, 8'hff);
        rdy_vec = 8'h10;
        exp_q.push_back(4'd5);
        cyc();
        ack_expect("wait kept");
        issue_ack = 1'b0;
        // reset with issue pending and 4 entries busy
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst2 err", err, 0);
        issue_ack = 1'b1;
        cyc();
        issue_ack = 1'b0;
        chk("ack idle err", err, 1);
        rdy_vec = 8'h0f;
        alloc_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        alloc_req = 1'b0;
        chk("pre-rst ivalid", issue_valid, 1);
        chk("pre-rst iid", issue_id, 1);
        chk("pre-rst busy", busy_vec, 8'h0f);
        rst_n = 1'b0;
        #1;
        chk("async ivalid", issue_valid, 0);
        chk("async iid", issue_id, 0);
        chk("async busy", busy_vec, 8'h00);
        chk("async empty", empty, 1);
        chk("async err", err, 0);
        cyc();
        rst_n = 1'b1;
        rdy_vec = 8'h00;
        done_valid = 1'b1; done_id = 4'd2;
        cyc();
        done_valid = 1'b0;
        chk("stale done err", err, 1);
        chk("stale done busy", busy_vec, 8'h00);
        // entries 2 and 5 ready among five waiting
        alloc_req = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        alloc_req = 1'b0;
        rdy_vec = 8'h12;
        exp_q.push_back(4'd2); exp_q.push_back(4'd5);
        cyc();
        ack_expect("t2");
        ack_expect("t2");
        issue_ack = 1'b0;
        chk("t2 valid", issue_valid, 0);
        chk("t2 id", issue_id, 0);
        chk("t2 busy", busy_vec, 8'h1f);
        chk("queue empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
